// File: rtl/eta_error_monitor.sv
// ---------------------------------------------------------------------------
// eta_error_monitor
//
// Measures the error of an approximate 16-bit adder against the exact sum
// over windows of WINDOW accepted samples and hands each window's statistics
// to a consumer with a valid/ready handshake.
//
// Optional feature: define ETA_ERR_BIAS_EN to build the signed error-bias
// accumulator. Without it, err_bias is tied to zero and no bias logic exists.
//
// Parameters
//   WINDOW        samples per report window (1..65535)
// Ports
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   clear         synchronous restart of the current window (flushes pipeline)
//   in_valid      sample offered
//   in_ready      sample accepted this cycle when in_valid is also high
//   a, b          exact adder operands
//   approx_s      approximate sum under test
//   approx_cout   approximate carry-out under test
//   report_valid  window statistics available (held until report_ready)
//   report_ready  consumer takes the report
//   err_cnt       samples with nonzero error distance
//   max_ed        largest error distance
//   sum_ed        total error distance, saturating
//   err_bias      signed sum of (approx - exact), saturating
// ---------------------------------------------------------------------------
module eta_error_monitor #(
    parameter int WINDOW = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] approx_s,
    input  logic        approx_cout,
    output logic        report_valid,
    input  logic        report_ready,
    output logic [15:0] err_cnt,
    output logic [16:0] max_ed,
    output logic [31:0] sum_ed,
    output logic [31:0] err_bias
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(WINDOW - 1);

    state_t       state_reg;
    logic         run_reg;
    logic         report_valid_reg;
    logic         drain_reg;
    logic [15:0]  cnt_reg;

    logic         s1_valid_reg;
    logic [16:0]  s1_exact_reg;
    logic [16:0]  s1_approx_reg;
    logic         s2_valid_reg;
    logic [16:0]  s2_ed_reg;

    logic [15:0]  err_cnt_reg;
    logic [16:0]  max_ed_reg;
    logic [31:0]  sum_ed_reg;

    logic         accept;
    logic         flush;
    logic         report_done;
    logic signed [17:0] diff_next;
    logic [16:0]  ed_next;
    logic [32:0]  sum_wide;

    // clear blocks acceptance combinationally so a sample offered alongside
    // clear is never taken.
    assign flush        = rst | clear;
    assign in_ready     = run_reg & ~clear;
    assign accept       = in_valid & in_ready;
    assign report_done  = (state_reg == REPORT) & report_ready;
    assign report_valid = report_valid_reg;
    assign err_cnt      = err_cnt_reg;
    assign max_ed       = max_ed_reg;
    assign sum_ed       = sum_ed_reg;

    // Signed distance in 18 bits; magnitude never exceeds 0x1FFFF so the
    // two's-complement negate of the low 17 bits is exact.
    always_comb begin
        diff_next = $signed({1'b0, s1_approx_reg}) - $signed({1'b0, s1_exact_reg});
        ed_next   = diff_next[17] ? (~diff_next[16:0] + 17'd1) : diff_next[16:0];
        sum_wide  = {1'b0, sum_ed_reg} + {16'd0, s2_ed_reg};
    end

`ifdef ETA_ERR_BIAS_EN
    logic signed [17:0] s2_diff_reg;
    logic [31:0]        err_bias_reg;
    logic [32:0]        bias_wide;

    assign err_bias  = err_bias_reg;
    assign bias_wide = {err_bias_reg[31], err_bias_reg} + {{15{s2_diff_reg[17]}}, s2_diff_reg};
`else
    assign err_bias = 32'd0;
`endif

    // Datapath registers: qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_exact_reg  <= {1'b0, a} + {1'b0, b};
            s1_approx_reg <= {approx_cout, approx_s};
        end
        s2_ed_reg <= ed_next;
`ifdef ETA_ERR_BIAS_EN
        s2_diff_reg <= diff_next;
`endif
    end

    // Control, accumulators and FSM. rst and clear have the same effect.
    always_ff @(posedge clk) begin
        if (flush) begin
            state_reg        <= RUN;
            run_reg          <= 1'b1;
            report_valid_reg <= 1'b0;
            drain_reg        <= 1'b0;
            cnt_reg          <= 16'd0;
            s1_valid_reg     <= 1'b0;
            s2_valid_reg     <= 1'b0;
            err_cnt_reg      <= 16'd0;
            max_ed_reg       <= 17'd0;
            sum_ed_reg       <= 32'd0;
`ifdef ETA_ERR_BIAS_EN
            err_bias_reg     <= 32'd0;
`endif
        end else begin
            s1_valid_reg <= accept;
            s2_valid_reg <= s1_valid_reg;

            if (report_done) begin
                err_cnt_reg <= 16'd0;
                max_ed_reg  <= 17'd0;
                sum_ed_reg  <= 32'd0;
`ifdef ETA_ERR_BIAS_EN
                err_bias_reg <= 32'd0;
`endif
            end else if (s2_valid_reg) begin
                if (s2_ed_reg != 17'd0) begin
                    err_cnt_reg <= err_cnt_reg + 16'd1;
                end
                if (s2_ed_reg > max_ed_reg) begin
                    max_ed_reg <= s2_ed_reg;
                end
                sum_ed_reg <= sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
`ifdef ETA_ERR_BIAS_EN
                // Overflow when the two top bits of the widened sum disagree.
                if (bias_wide[32] != bias_wide[31]) begin
                    err_bias_reg <= bias_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end else begin
                    err_bias_reg <= bias_wide[31:0];
                end
`endif
            end

            case (state_reg)
                RUN: begin
                    if (accept) begin
                        if (cnt_reg == LAST_IDX) begin
                            state_reg <= DRAIN;
                            run_reg   <= 1'b0;
                            drain_reg <= 1'b0;
                            cnt_reg   <= 16'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles let the last accepted sample reach the
                    // accumulators before the report is raised.
                    if (drain_reg) begin
                        state_reg        <= REPORT;
                        report_valid_reg <= 1'b1;
                    end else begin
                        drain_reg <= 1'b1;
                    end
                end
                REPORT: begin
                    if (report_ready) begin
                        state_reg        <= RUN;
                        run_reg          <= 1'b1;
                        report_valid_reg <= 1'b0;
                        cnt_reg          <= 16'd0;
                    end
                end
                default: begin
                    state_reg        <= RUN;
                    run_reg          <= 1'b1;
                    report_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eta_error_monitor.sv
module tb_eta_error_monitor;

    localparam int W = 4;
`ifdef ETA_ERR_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic [15:0] approx_s = 16'd0;
    logic        approx_cout = 1'b0;
    logic        report_valid;
    logic        report_ready = 1'b0;
    logic [15:0] err_cnt;
    logic [16:0] max_ed;
    logic [31:0] sum_ed;
    logic [31:0] err_bias;

    // Second instance for the single-sample window boundary
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic        report_valid1;
    logic        report_ready1 = 1'b0;
    logic [15:0] err_cnt1;
    logic [16:0] max_ed1;
    logic [31:0] sum_ed1;
    logic [31:0] err_bias1;

    always #5 clk = ~clk;

    eta_error_monitor #(.WINDOW(W)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx_s(approx_s), .approx_cout(approx_cout),
        .report_valid(report_valid), .report_ready(report_ready),
        .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed), .err_bias(err_bias)
    );

    eta_error_monitor #(.WINDOW(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .approx_s(approx_s), .approx_cout(approx_cout),
        .report_valid(report_valid1), .report_ready(report_ready1),
        .err_cnt(err_cnt1), .max_ed(max_ed1), .sum_ed(sum_ed1), .err_bias(err_bias1)
    );

    typedef struct {
        logic [15:0] ec;
        logic [16:0] mx;
        logic [31:0] sm;
        logic [31:0] bs;
    } rep_t;

    rep_t   exp_q[$];
    int     n_vec  = 0;
    int     n_miss = 0;
    int     n_rep  = 0;

    // Reference model of one window
    int     m_cnt;
    int     m_err;
    int     m_max;
    longint m_sum;
    longint m_bias;

    function automatic void model_reset();
        m_cnt  = 0;
        m_err  = 0;
        m_max  = 0;
        m_sum  = 0;
        m_bias = 0;
    endfunction

    function automatic void model_add(input logic [15:0] fa, input logic [15:0] fb,
                                      input logic [15:0] fs, input logic fc);
        int   ex;
        int   ap;
        int   d;
        int   ed;
        rep_t r;
        ex = int'(fa) + int'(fb);
        ap = int'({fc, fs});
        d  = ap - ex;
        ed = (d < 0) ? -d : d;
        if (ed != 0) m_err++;
        if (ed > m_max) m_max = ed;
        m_sum += ed;
        if (m_sum > 64'sh0000_0000_FFFF_FFFF) m_sum = 64'sh0000_0000_FFFF_FFFF;
        m_bias += d;
        if (m_bias > 64'sd2147483647) m_bias = 64'sd2147483647;
        if (m_bias < -64'sd2147483648) m_bias = -64'sd2147483648;
        m_cnt++;
        if (m_cnt == W) begin
            r.ec = m_err[15:0];
            r.mx = m_max[16:0];
            r.sm = m_sum[31:0];
            r.bs = BIAS_EN ? m_bias[31:0] : 32'd0;
            exp_q.push_back(r);
            model_reset();
        end
    endfunction

    // One cycle of stimulus: inputs set after the falling edge, acceptance
    // observed before the rising edge, model updated on acceptance.
    task automatic drive(input logic v, input logic [15:0] da, input logic [15:0] db,
                         input logic [15:0] ds, input logic dc, input logic clr,
                         output logic acc);
        @(negedge clk);
        in_valid    = v;
        a           = da;
        b           = db;
        approx_s    = ds;
        approx_cout = dc;
        clear       = clr;
        #1;
        acc = in_valid & in_ready;
        @(posedge clk);
        if (clr) model_reset();
        else if (acc) model_add(da, db, ds, dc);
    endtask

    // Wait for a report, compare it with the scoreboard head, optionally
    // complete the handshake and confirm the return to a clean RUN state.
    task automatic wait_report(input int budget, input logic do_hs);
        int   n;
        rep_t e;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!report_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (!report_valid) begin
            n_miss++;
            $display("FAIL report_timeout: report_valid=%b after %0d cycles, required 1", report_valid, n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL report_unexpected: report_valid=1 with empty scoreboard, required no report");
            return;
        end
        e = exp_q.pop_front();
        n_rep++;
        $display("report %0d: err_cnt=%0d max_ed=0x%05h sum_ed=0x%08h err_bias=0x%08h",
                 n_rep, err_cnt, max_ed, sum_ed, err_bias);
        n_vec++;
        if (err_cnt !== e.ec) begin
            n_miss++;
            $display("FAIL err_cnt: got %0d, required %0d", err_cnt, e.ec);
        end
        n_vec++;
        if (max_ed !== e.mx) begin
            n_miss++;
            $display("FAIL max_ed: got 0x%05h, required 0x%05h", max_ed, e.mx);
        end
        n_vec++;
        if (sum_ed !== e.sm) begin
            n_miss++;
            $display("FAIL sum_ed: got 0x%08h, required 0x%08h", sum_ed, e.sm);
        end
        n_vec++;
        if (err_bias !== e.bs) begin
            n_miss++;
            $display("FAIL err_bias: got 0x%08h, required 0x%08h", err_bias, e.bs);
        end
        if (do_hs) begin
            report_ready = 1'b1;
            @(posedge clk);
            #1 report_ready = 1'b0;
            @(negedge clk);
            n_vec++;
            if (report_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 16'd0 ||
                max_ed !== 17'd0 || sum_ed !== 32'd0 || err_bias !== 32'd0) begin
                n_miss++;
                $display("FAIL post_handshake: rv=%b rdy=%b cnt=%0d max=%0h sum=%0h bias=%0h, required 0 1 0 0 0 0",
                         report_valid, in_ready, err_cnt, max_ed, sum_ed, err_bias);
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        clear    = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (report_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_report_valid: got %b, required 0", report_valid);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        n_vec++;
        if (err_cnt !== 16'd0 || max_ed !== 17'd0 || sum_ed !== 32'd0 || err_bias !== 32'd0) begin
            n_miss++;
            $display("FAIL reset_stats: got %0h %0h %0h %0h, required all 0", err_cnt, max_ed, sum_ed, err_bias);
        end
        model_reset();
    endtask

    task automatic test_no_error();
        logic acc;
        for (int i = 0; i < W; i++) drive(1'b1, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, acc);
        wait_report(10, 1'b1);
    endtask

    task automatic test_ed_one();
        logic acc;
        drive(1'b1, 16'h00FF, 16'h0001, 16'h00FF, 1'b0, 1'b0, acc);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, acc);
        drive(1'b0, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, acc);
        drive(1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, acc);
        wait_report(10, 1'b1);
    endtask

    task automatic test_max_ed();
        logic acc;
        drive(1'b1, 16'h0003, 16'h0004, 16'h0005, 1'b0, 1'b0, acc);
        drive(1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, acc);
        drive(1'b1, 16'h0100, 16'h0100, 16'h0210, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, acc);
        wait_report(10, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic acc;
        rep_t e;
        drive(1'b1, 16'h1000, 16'h0001, 16'h1003, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h2000, 16'h2000, 16'h4000, 1'b0, 1'b0, acc);
        drive(1'b1, 16'hF000, 16'h2000, 16'h1000, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0040, 16'h0040, 16'h0070, 1'b0, 1'b0, acc);
        // in_valid stays high through the drain
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL drain_in_ready[%0d]: got %b, required 0", k, in_ready);
            end
            n_vec++;
            if (report_valid !== (k == 2)) begin
                n_miss++;
                $display("FAIL report_latency[%0d]: report_valid=%b, required %b", k, report_valid, (k == 2));
            end
        end
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL stall_scoreboard: queue empty, required one report");
            return;
        end
        e = exp_q.pop_front();
        n_rep++;
        $display("report %0d: err_cnt=%0d max_ed=0x%05h sum_ed=0x%08h err_bias=0x%08h (held)",
                 n_rep, err_cnt, max_ed, sum_ed, err_bias);
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (report_valid !== 1'b1 || in_ready !== 1'b0 || err_cnt !== e.ec ||
                max_ed !== e.mx || sum_ed !== e.sm || err_bias !== e.bs) begin
                n_miss++;
                $display("FAIL stall_hold[%0d]: rv=%b rdy=%b %0h %0h %0h %0h, required 1 0 %0h %0h %0h %0h",
                         k, report_valid, in_ready, err_cnt, max_ed, sum_ed, err_bias,
                         e.ec, e.mx, e.sm, e.bs);
            end
            @(negedge clk);
        end
        in_valid     = 1'b0;
        report_ready = 1'b1;
        @(posedge clk);
        #1 report_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (report_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 16'd0 ||
            max_ed !== 17'd0 || sum_ed !== 32'd0 || err_bias !== 32'd0) begin
            n_miss++;
            $display("FAIL stall_release: rv=%b rdy=%b %0h %0h %0h %0h, required 0 1 0 0 0 0",
                     report_valid, in_ready, err_cnt, max_ed, sum_ed, err_bias);
        end
    endtask

    task automatic test_clear();
        logic acc;
        drive(1'b1, 16'h0100, 16'h0001, 16'h0109, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0200, 16'h0001, 16'h0300, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0300, 16'h0001, 16'h0000, 1'b0, 1'b1, acc);
        n_vec++;
        if (acc !== 1'b0) begin
            n_miss++;
            $display("FAIL clear_accept: accepted=%b during clear, required 0", acc);
        end
        for (int k = 0; k < 3; k++) drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, acc);
        @(negedge clk);
        n_vec++;
        if (err_cnt !== 16'd0 || sum_ed !== 32'd0 || max_ed !== 17'd0 || report_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL clear_flush: cnt=%0d sum=%0h max=%0h rv=%b, required 0 0 0 0",
                     err_cnt, sum_ed, max_ed, report_valid);
        end
        drive(1'b1, 16'h0010, 16'h0001, 16'h0011, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0020, 16'h0001, 16'h0025, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0030, 16'h0001, 16'h0031, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0040, 16'h0001, 16'h0038, 1'b0, 1'b0, acc);
        wait_report(10, 1'b1);
    endtask

    task automatic test_rst_in_report();
        logic acc;
        drive(1'b1, 16'h0500, 16'h0500, 16'h0A07, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0600, 16'h0001, 16'h0500, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0700, 16'h0001, 16'h0701, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0800, 16'h0001, 16'h0811, 1'b0, 1'b0, acc);
        wait_report(10, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (report_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 16'd0 ||
            max_ed !== 17'd0 || sum_ed !== 32'd0 || err_bias !== 32'd0) begin
            n_miss++;
            $display("FAIL rst_in_report: rv=%b rdy=%b %0h %0h %0h %0h, required 0 1 0 0 0 0",
                     report_valid, in_ready, err_cnt, max_ed, sum_ed, err_bias);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_window1();
        logic [31:0] eb;
        eb = BIAS_EN ? 32'hFFFF_0002 : 32'd0;
        @(negedge clk);
        in_valid    = 1'b0;
        clear       = 1'b0;
        in_valid1   = 1'b1;
        a           = 16'hFFFF;
        b           = 16'hFFFF;
        approx_s    = 16'h0000;
        approx_cout = 1'b1;
        #1;
        n_vec++;
        if (in_ready1 !== 1'b1) begin
            n_miss++;
            $display("FAIL w1_ready: got %b, required 1", in_ready1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        n_vec++;
        if (in_ready1 !== 1'b0) begin
            n_miss++;
            $display("FAIL w1_drain: in_ready=%b, required 0", in_ready1);
        end
        @(negedge clk);
        @(negedge clk);
        $display("w1 report: err_cnt=%0d max_ed=0x%05h sum_ed=0x%08h err_bias=0x%08h",
                 err_cnt1, max_ed1, sum_ed1, err_bias1);
        n_vec++;
        if (report_valid1 !== 1'b1 || err_cnt1 !== 16'd1 || max_ed1 !== 17'h0FFFE ||
            sum_ed1 !== 32'h0000_FFFE || err_bias1 !== eb) begin
            n_miss++;
            $display("FAIL w1_report: rv=%b %0h %0h %0h %0h, required 1 1 fffe fffe %0h",
                     report_valid1, err_cnt1, max_ed1, sum_ed1, err_bias1, eb);
        end
        report_ready1 = 1'b1;
        @(posedge clk);
        #1 report_ready1 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (report_valid1 !== 1'b0 || in_ready1 !== 1'b1 || err_cnt1 !== 16'd0) begin
            n_miss++;
            $display("FAIL w1_release: rv=%b rdy=%b cnt=%0d, required 0 1 0",
                     report_valid1, in_ready1, err_cnt1);
        end
    endtask

    task automatic test_random();
        logic        acc;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [16:0] ex;
        logic [16:0] ap;
        int          got;
        int          guard;
        for (int w = 0; w < 3; w++) begin
            got   = 0;
            guard = 0;
            while (got < W && guard < 40) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                ex = {1'b0, ra} + {1'b0, rb};
                case ($urandom_range(3))
                    0:       ap = ex;
                    1:       ap = ex + 17'($urandom_range(8, 1));
                    2:       ap = ex - 17'($urandom_range(8, 1));
                    default: ap = 17'($urandom);
                endcase
                drive(($urandom_range(3) != 0), ra, rb, ap[15:0], ap[16], 1'b0, acc);
                if (acc) got++;
                guard++;
            end
            wait_report(10, 1'b1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_no_error();
        test_ed_one();
        test_max_ed();
        test_back_to_back();
        test_clear();
        test_rst_in_report();
        test_window1();
        test_random();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d reports outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eta_error_monitor.md
ETA_ERROR_MONITOR -- requirements
Module: eta_error_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 256, meaning samples per report window (range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port clear  input  1  synchronous restart of the current window.
REQ-005 SHALL have port in_valid  input  1  sample offered.
REQ-006 SHALL have port in_ready  output  1  monitor accepts the sample this cycle.
REQ-007 SHALL have ports a, b  input  16 each  adder operands.
REQ-008 SHALL have ports approx_s  input  16 and approx_cout  input  1  approximate adder sum and carry under test.
REQ-009 SHALL have port report_valid  output  1  window statistics available.
REQ-010 SHALL have port report_ready  input  1  consumer takes the report.
REQ-011 SHALL have ports err_cnt  output  16 (samples with nonzero error), max_ed  output  17 (largest error distance), sum_ed  output  32 (total error distance).
REQ-012 SHALL have port err_bias  output  32  signed sum of (approx - exact); see Configuration.

Function
REQ-013 SHALL accept a sample when in_valid and in_ready are both 1.
REQ-014 SHALL form exact = a + b (17 bits) and approx = {approx_cout, approx_s} (17 bits).
REQ-015 SHALL compute ED = |exact - approx| in 17 bits, with no truncation.
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers the accepted sample and exact; stage 2 registers ED and updates the accumulators.
REQ-017 Accumulators SHALL reflect a sample 2 cycles after its accept edge.
REQ-018 SHALL use an FSM with states RUN, DRAIN, REPORT.
REQ-019 RUN: in_ready = 1; an accept-counter counts accepts; on the WINDOW-th accept the FSM SHALL go to DRAIN.
REQ-020 DRAIN: in_ready = 0; after 2 cycles (pipeline empty) the FSM SHALL go to REPORT.
REQ-021 REPORT: in_ready = 0 and report_valid = 1, with err_cnt, max_ed, sum_ed, err_bias held stable.
REQ-022 REPORT SHALL exit when report_valid and report_ready are both 1: the FSM SHALL go to RUN and zero all accumulators and the counter on that edge.
REQ-023 report_valid SHALL NOT drop before the handshake completes.
REQ-024 Statistic outputs SHALL be valid only while report_valid = 1, and SHALL show the running values otherwise.
REQ-025 An accept while in_valid = 0 SHALL NOT occur; an idle cycle SHALL leave all statistics unchanged.
REQ-026 err_cnt SHALL increment when ED != 0.
REQ-027 max_ed SHALL update when ED > max_ed.
REQ-028 sum_ed SHALL saturate at 0xFFFFFFFF.
REQ-029 err_bias SHALL saturate at the signed 32-bit limits.
REQ-030 clear = 1 SHALL flush the pipeline, zero the accumulators and counter, and force RUN, in any state; a sample offered on that cycle SHALL NOT be accepted (in_ready = 0 while clear = 1).
REQ-031 If rst and clear are both 1, rst SHALL take priority; the outcome is identical.
REQ-032 WINDOW = 1 SHALL give RUN -> DRAIN after a single accept.

Reset
REQ-033 On rst the FSM SHALL enter RUN and the pipeline valid bits SHALL clear.
REQ-034 On rst the accept-counter, err_cnt, max_ed, sum_ed and err_bias SHALL be 0.
REQ-035 Outputs out of reset SHALL be in_ready = 1 (when clear = 0) and report_valid = 0.
REQ-036 Reset asserted mid-window or mid-REPORT SHALL discard all pending data and statistics.

Configuration
REQ-037 Macro ETA_ERR_BIAS_EN defined: the signed error-bias accumulator SHALL be implemented as described.
REQ-038 Macro ETA_ERR_BIAS_EN undefined: no bias accumulator logic SHALL exist, and err_bias SHALL be constant 0.
REQ-039 All other behaviour SHALL be identical with or without ETA_ERR_BIAS_EN.

Verification
REQ-040 Scenario 1: WINDOW = 4; 4 samples with a = 0x1234, b = 0x0001, approx = 0x1235 -> REPORT with err_cnt = 0, max_ed = 0, sum_ed = 0, err_bias = 0.
REQ-041 Scenario 2: a = 0x00FF, b = 0x0001, approx_s = 0x00FF, approx_cout = 0 -> ED = 1; err_bias = -1 when ETA_ERR_BIAS_EN is defined.
REQ-042 Scenario 3: a = 0xFFFF, b = 0xFFFF, approx = {1, 0x0000} -> exact = 0x1FFFE, ED = 0xFFFE, max_ed = 0x0FFFE, err_bias = -65534.
REQ-043 Scenario 4: WINDOW = 4 with continuous in_valid -> in_ready low on the cycle after the 4th accept, report_valid high 2 cycles later; report_ready held 0 for 10 cycles -> outputs stable; report_ready = 1 -> RUN next cycle with zeroed statistics.
REQ-044 Scenario 5: clear pulsed after 2 of 4 accepts, one sample in flight -> in-flight sample not counted, window restarts, the next 4 accepts produce the report.
REQ-045 Scenario 6: rst asserted during REPORT -> next cycle report_valid = 0, in_ready = 1, all statistics 0.
